// File: rtl/gate_chk_pkg.sv
// Shared types and observation bit positions for the gate response checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chkState_t;

    localparam int AND   = 0;
    localparam int OR    = 1;
    localparam int NOT   = 2;
    localparam int NAND  = 3;
    localparam int NAND2 = 4;
    localparam int OBS_W = 5;

endpackage

// File: rtl/gate_resp_checker_if.sv
// Observation handshake between the stimulus driver (master) and the checker (slave).
interface gate_resp_checker_if;
    import gate_chk_pkg::*;

    logic             iValid;
    logic             oReady;
    logic             iA;
    logic             iB;
    logic [OBS_W-1:0] iObs;

    modport master (output iValid, iA, iB, iObs, input oReady);
    modport slave  (input iValid, iA, iB, iObs, output oReady);

endinterface

// File: rtl/gate_ref_model.sv
// Golden gate-unit model: applied {iA,iB} to the expected 5-bit output vector.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic             iA,
    input  logic             iB,
    output logic [OBS_W-1:0] oExp
);

    always_comb begin
        oExp        = '0;
        oExp[AND]   = iA & iB;
        oExp[OR]    = iA | iB;
        oExp[NOT]   = ~iA;
        oExp[NAND]  = ~(iA & iB);
        oExp[NAND2] = ~(iA & iB);
    end

endmodule

// File: rtl/gate_resp_checker.sv
// Gate-unit response checker: stages each observation, compares it one cycle later, reports done/pass.
// Optional first-error capture ports are enabled with `define GATE_CHK_CAPTURE_EN.
//  state | meaning
//  IDLE  | after reset, waiting for iStart
//  RUN   | accepting observations (oReady=1)
//  DRAIN | last staged vector being compared
//  DONE  | result held until next iStart
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int NUM_VEC = 4,
    parameter int CNT_W   = 8,
    parameter int ERR_W   = 8
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iStart,
    gate_resp_checker_if.slave bus,
    output logic               oBusy,
    output logic               oDone,
    output logic               oPass,
    output logic [CNT_W-1:0]   oVecCnt,
    output logic [ERR_W-1:0]   oErrCnt
`ifdef GATE_CHK_CAPTURE_EN
    ,
    output logic [CNT_W-1:0]   oFirstErrIdx,
    output logic [OBS_W-1:0]   oFirstErrMask
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

    chkState_t        state, nextState;
    logic             ready;
    logic             hs;
    logic             startOk;
    logic             stgValid;
    logic             stgA, stgB;
    logic [OBS_W-1:0] stgObs;
    logic [OBS_W-1:0] expVec;
    logic [OBS_W-1:0] diff;
    logic             mismatch;
    logic [CNT_W-1:0] vecCnt;
    logic [ERR_W-1:0] errCnt;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        ready     = 1'b0;
        oBusy     = 1'b0;
        oDone     = 1'b0;
        unique case (state)
            IDLE: if (iStart) nextState = RUN;
            RUN: begin
                ready = 1'b1;
                oBusy = 1'b1;
                if (bus.iValid && vecCnt == LAST_IDX) nextState = DRAIN;
            end
            DRAIN: begin
                oBusy     = 1'b1;
                nextState = DONE;
            end
            DONE: begin
                oDone = 1'b1;
                if (iStart) nextState = RUN;
            end
            default: nextState = IDLE;
        endcase
    end

    assign bus.oReady = ready;
    assign hs         = ready & bus.iValid;
    assign startOk    = iStart & ~oBusy;

    gate_ref_model uRef (.iA(stgA), .iB(stgB), .oExp(expVec));

    assign diff     = expVec ^ stgObs;
    assign mismatch = |diff;

    // Compare runs one cycle behind capture so back-to-back handshakes need no bubbles.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stgValid <= 1'b0;
            stgA     <= 1'b0;
            stgB     <= 1'b0;
            stgObs   <= '0;
            vecCnt   <= '0;
            errCnt   <= '0;
        end else if (startOk) begin
            stgValid <= 1'b0;
            vecCnt   <= '0;
            errCnt   <= '0;
        end else begin
            stgValid <= hs;
            if (hs) begin
                stgA   <= bus.iA;
                stgB   <= bus.iB;
                stgObs <= bus.iObs;
                vecCnt <= vecCnt + 1'b1;
            end
            if (stgValid && mismatch && errCnt != '1) errCnt <= errCnt + 1'b1;
        end
    end

    assign oVecCnt = vecCnt;
    assign oErrCnt = errCnt;
    assign oPass   = oDone & (errCnt == '0);

`ifdef GATE_CHK_CAPTURE_EN
    logic [CNT_W-1:0] stgIdx;

    // A captured mask is never zero, so a zero mask doubles as "nothing captured yet".
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stgIdx        <= '0;
            oFirstErrIdx  <= '0;
            oFirstErrMask <= '0;
        end else if (startOk) begin
            stgIdx        <= '0;
            oFirstErrIdx  <= '0;
            oFirstErrMask <= '0;
        end else begin
            if (hs) stgIdx <= vecCnt;
            if (stgValid && mismatch && oFirstErrMask == '0) begin
                oFirstErrIdx  <= stgIdx;
                oFirstErrMask <= diff;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gate_resp_checker.sv
// Randomized bench for gate_resp_checker: two instances (4-vector/8-bit errors, 6-vector/2-bit errors)
// checked every cycle against a flag-and-counter reference model built from the checker's rules.
module tb_gate_resp_checker;
    import gate_chk_pkg::*;

    logic iClk = 1'b0;
    logic iRst;
    always #5 iClk = ~iClk;

    bit       drvStart [2];
    bit       drvValid [2];
    bit       drvA     [2];
    bit       drvB     [2];
    bit [4:0] drvObs   [2];

    gate_resp_checker_if bus0 ();
    gate_resp_checker_if bus1 ();

    assign bus0.iValid = drvValid[0];
    assign bus0.iA     = drvA[0];
    assign bus0.iB     = drvB[0];
    assign bus0.iObs   = drvObs[0];
    assign bus1.iValid = drvValid[1];
    assign bus1.iA     = drvA[1];
    assign bus1.iB     = drvB[1];
    assign bus1.iObs   = drvObs[1];

    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0] vec0, err0, vec1;
    logic [1:0] err1;
`ifdef GATE_CHK_CAPTURE_EN
    logic [7:0] fIdx0, fIdx1;
    logic [4:0] fMask0, fMask1;
`endif

    gate_resp_checker #(.NUM_VEC(4), .CNT_W(8), .ERR_W(8)) dut0 (
        .iClk(iClk), .iRst(iRst), .iStart(drvStart[0]), .bus(bus0),
        .oBusy(busy0), .oDone(done0), .oPass(pass0), .oVecCnt(vec0), .oErrCnt(err0)
`ifdef GATE_CHK_CAPTURE_EN
        , .oFirstErrIdx(fIdx0), .oFirstErrMask(fMask0)
`endif
    );

    gate_resp_checker #(.NUM_VEC(6), .CNT_W(8), .ERR_W(2)) dut1 (
        .iClk(iClk), .iRst(iRst), .iStart(drvStart[1]), .bus(bus1),
        .oBusy(busy1), .oDone(done1), .oPass(pass1), .oVecCnt(vec1), .oErrCnt(err1)
`ifdef GATE_CHK_CAPTURE_EN
        , .oFirstErrIdx(fIdx1), .oFirstErrMask(fMask1)
`endif
    );

    logic       refA, refB;
    logic [4:0] refExp;
    gate_ref_model refChk (.iA(refA), .iB(refB), .oExp(refExp));

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Truth table written as plain arithmetic on 0/1 values.
    function automatic int expOf(input int a, input int b);
        int andV, orV, notV, nandV;
        andV  = a * b;
        orV   = (a + b > 0) ? 1 : 0;
        notV  = 1 - a;
        nandV = 1 - andV;
        return andV + 2 * orV + 4 * notV + 8 * nandV + 16 * nandV;
    endfunction

    int numVec [2] = '{4, 6};
    int errMax [2] = '{255, 3};
    int mRun [2], mDrain [2], mDone [2], mAcc [2], mErr [2];
    int mPend [2], mPendIdx [2], mPendMask [2], mFIdx [2], mFMask [2], mSeen [2];

    task automatic modelClear(input int u);
        mDrain[u] = 0; mDone[u] = 0; mAcc[u] = 0; mErr[u] = 0;
        mPend[u] = 0; mPendIdx[u] = 0; mPendMask[u] = 0;
        mFIdx[u] = 0; mFMask[u] = 0; mSeen[u] = 0;
    endtask

    task automatic modelReset(input int u);
        modelClear(u);
        mRun[u] = 0;
    endtask

    task automatic modelEdge(input int u);
        if (mRun[u] == 0 && drvStart[u]) begin
            modelClear(u);
            mRun[u] = 1;
            return;
        end
        if (mPend[u] != 0) begin
            if (mPendMask[u] != 0) begin
                if (mErr[u] < errMax[u]) mErr[u]++;
                if (mSeen[u] == 0) begin
                    mSeen[u] = 1; mFIdx[u] = mPendIdx[u]; mFMask[u] = mPendMask[u];
                end
            end
            mPend[u] = 0;
        end
        if (mDrain[u] != 0) begin
            mDrain[u] = 0; mRun[u] = 0; mDone[u] = 1;
        end else if (mRun[u] != 0 && drvValid[u]) begin
            mPend[u]     = 1;
            mPendIdx[u]  = mAcc[u];
            mPendMask[u] = expOf(int'(drvA[u]), int'(drvB[u])) ^ int'(drvObs[u]);
            mAcc[u]++;
            if (mAcc[u] == numVec[u]) mDrain[u] = 1;
        end
    endtask

    task automatic compareUnit(input int u, input logic rdy, input logic bsy, input logic dn,
                               input logic ps, input logic [31:0] vc, input logic [31:0] ec);
        checkVal($sformatf("u%0d_ready", u), rdy, (mRun[u] != 0 && mDrain[u] == 0));
        checkVal($sformatf("u%0d_busy", u), bsy, (mRun[u] != 0));
        checkVal($sformatf("u%0d_done", u), dn, (mDone[u] != 0));
        checkVal($sformatf("u%0d_pass", u), ps, (mDone[u] != 0 && mErr[u] == 0));
        checkVal($sformatf("u%0d_vecCnt", u), vc, mAcc[u]);
        checkVal($sformatf("u%0d_errCnt", u), ec, mErr[u]);
    endtask

    task automatic compareAll();
        compareUnit(0, bus0.oReady, busy0, done0, pass0, 32'(vec0), 32'(err0));
        compareUnit(1, bus1.oReady, busy1, done1, pass1, 32'(vec1), 32'(err1));
`ifdef GATE_CHK_CAPTURE_EN
        checkVal("u0_firstIdx", 32'(fIdx0), mFIdx[0]);
        checkVal("u0_firstMask", 32'(fMask0), mFMask[0]);
        checkVal("u1_firstIdx", 32'(fIdx1), mFIdx[1]);
        checkVal("u1_firstMask", 32'(fMask1), mFMask[1]);
`endif
    endtask

    task automatic cycle();
        @(posedge iClk);
        for (int u = 0; u < 2; u++) begin
            if (iRst) modelReset(u);
            else      modelEdge(u);
        end
        #1;
        compareAll();
    endtask

    task automatic doReset();
        #2;
        iRst = 1'b1;
        #1;
        modelReset(0);
        modelReset(1);
        compareAll();
        cycle();
        iRst = 1'b0;
    endtask

    task automatic pulseStart(input int u);
        drvStart[u] = 1'b1;
        cycle();
        drvStart[u] = 1'b0;
    endtask

    // mode 0: all correct; 1: vector 2 has OR bit forced to 0; 2: every vector wrong
    task automatic runVectors(input int u, input int mode, input bit gaps);
        int n = 0;
        while (mDone[u] == 0 && n < 200) begin
            int idx, a, b, flip;
            idx  = mAcc[u];
            a    = (idx >> 1) & 1;
            b    = idx & 1;
            flip = 0;
            if (mode == 1 && idx == 2) flip = 5'b00010;
            if (mode == 2) flip = int'($urandom_range(1, 31));
            drvA[u]     = a[0];
            drvB[u]     = b[0];
            drvObs[u]   = 5'(expOf(a, b) ^ flip);
            drvValid[u] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            n++;
        end
        checkVal($sformatf("u%0d_run_completes", u), (u == 0) ? done0 : done1, 1);
        drvValid[u] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iRst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            drvStart[u] = 0; drvValid[u] = 0; drvA[u] = 0; drvB[u] = 0; drvObs[u] = '0;
        end
        #1;
        modelReset(0);
        modelReset(1);
        compareAll();

        for (int k = 0; k < 4; k++) begin
            refA = k[1];
            refB = k[0];
            #1;
            checkVal($sformatf("refModel_ab%0d", k), 32'(refExp), expOf(k / 2, k % 2));
        end

        cycle();
        cycle();
        iRst = 1'b0;
        cycle();

        // 1) all correct, iValid held high
        pulseStart(0);
        runVectors(0, 0, 1'b0);
        checkVal("t1_vecCnt", 32'(vec0), 4);
        checkVal("t1_pass", pass0, 1);

        // 2) vector 2 with OR bit wrong
        pulseStart(0);
        runVectors(0, 1, 1'b0);
        checkVal("t2_errCnt", 32'(err0), 1);
        checkVal("t2_pass", pass0, 0);
`ifdef GATE_CHK_CAPTURE_EN
        checkVal("t2_firstIdx", 32'(fIdx0), 2);
        checkVal("t2_firstMask", 32'(fMask0), 5'b00010);
`endif

        // 5) reset after two handshakes, then a clean run
        pulseStart(0);
        drvValid[0] = 1'b1;
        drvA[0] = 1'b1; drvB[0] = 1'b1; drvObs[0] = 5'(expOf(1, 1));
        cycle();
        cycle();
        drvValid[0] = 1'b0;
        checkVal("t5_preResetVecCnt", 32'(vec0), 2);
        doReset();
        checkVal("t5_busyAfterReset", busy0, 0);

        // 3) iValid pulses in IDLE are ignored, then a run with gaps
        for (int i = 0; i < 6; i++) begin
            drvValid[0] = 1'(i % 2);
            cycle();
        end
        drvValid[0] = 1'b0;
        checkVal("t3_idleVecCnt", 32'(vec0), 0);
        pulseStart(0);
        runVectors(0, 0, 1'b1);
        checkVal("t3_vecCnt", 32'(vec0), 4);
        checkVal("t5_cleanPass", pass0, 1);

        // 6) iStart together with iValid in DONE: restart only
        drvStart[0] = 1'b1;
        drvValid[0] = 1'b1;
        drvA[0] = 1'b0; drvB[0] = 1'b0; drvObs[0] = 5'(expOf(0, 0));
        cycle();
        drvStart[0] = 1'b0;
        drvValid[0] = 1'b0;
        checkVal("t6_vecCntCleared", 32'(vec0), 0);
        checkVal("t6_doneCleared", done0, 0);
        runVectors(0, 0, 1'b0);
        checkVal("t6_pass", pass0, 1);

        // 4) error counter saturation on the 6-vector, 2-bit instance
        pulseStart(1);
        runVectors(1, 2, 1'b0);
        checkVal("t4_errCntSat", 32'(err1), 3);
        checkVal("t4_vecCnt", 32'(vec1), 6);
        checkVal("t4_pass", pass1, 0);

        // random traffic on both instances
        for (int i = 0; i < 800; i++) begin
            for (int u = 0; u < 2; u++) begin
                int a, b, flip;
                a    = int'($urandom_range(0, 1));
                b    = int'($urandom_range(0, 1));
                flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 0;
                drvStart[u] = ($urandom_range(0, 11) == 0);
                drvValid[u] = 1'($urandom_range(0, 1));
                drvA[u]     = a[0];
                drvB[u]     = b[0];
                drvObs[u]   = 5'(expOf(a, b) ^ flip);
            end
            if ($urandom_range(0, 199) == 0) doReset();
            else cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
